// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: per-channel synchroniser, stability filter,
// mode-qualified edge pulse, sticky flag and saturating edge counter.
module multi_edge_detect #(
  parameter int   NCH         = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 4,
  parameter int   CNT_W       = 8,
  parameter logic IDLE_VAL    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       din,
  input  logic [1:0]           mode,
  input  logic [NCH-1:0]       clr,
  output logic [NCH-1:0]       level,
  output logic [NCH-1:0]       edge_pulse,
  output logic [NCH-1:0]       edge_flag,
  output logic [NCH*CNT_W-1:0] edge_cnt
);

  localparam int              FW        = (FILT_LEN < 1) ? 1 : $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0]   FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {NCH{IDLE_VAL}};
      end
    end else begin
      sync_q[0] <= din;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [FW-1:0]    filt_cnt;
    logic [CNT_W-1:0] cnt;
    logic             lvl;
    logic             pulse;
    logic             flag;
    logic             accept;
    logic             qual;

    // A change is accepted on the edge where the mismatch run would reach FILT_LEN.
    always_comb begin
      accept = (sync[i] != lvl) && (filt_cnt == FILT_LAST);
      qual   = 1'b0;
      if (accept) begin
        unique case (mode)
          2'b01:   qual = sync[i];
          2'b10:   qual = ~sync[i];
          2'b11:   qual = 1'b1;
          default: qual = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        filt_cnt <= '0;
        lvl      <= IDLE_VAL;
        pulse    <= 1'b0;
        flag     <= 1'b0;
        cnt      <= '0;
      end else begin
        if (sync[i] == lvl) begin
          filt_cnt <= '0;
        end else if (accept) begin
          filt_cnt <= '0;
          lvl      <= sync[i];
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end

        pulse <= qual;

        // A qualifying edge wins over a coincident clear for both flag and count.
        if (qual) begin
          flag <= 1'b1;
        end else if (clr[i]) begin
          flag <= 1'b0;
        end

        if (clr[i]) begin
          cnt <= qual ? CNT_W'(1) : '0;
        end else if (qual && (cnt != CNT_MAX)) begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign level[i]                    = lvl;
    assign edge_pulse[i]               = pulse;
    assign edge_flag[i]                = flag;
    assign edge_cnt[i*CNT_W +: CNT_W]  = cnt;
  end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Randomised and directed bench for multi_edge_detect with a queue-based
// scoreboard fed by a behavioural model of the filtering and counting rules.
module tb_multi_edge_detect;

  localparam int   NCH         = 4;
  localparam int   SYNC_STAGES = 2;
  localparam int   FILT_LEN    = 4;
  localparam int   CNT_W       = 8;
  localparam logic IDLE_VAL    = 1'b1;
  localparam int   CNT_SAT     = (1 << CNT_W) - 1;

  logic                 clk;
  logic                 rst;
  logic [NCH-1:0]       din;
  logic [1:0]           mode;
  logic [NCH-1:0]       clr;
  logic [NCH-1:0]       level;
  logic [NCH-1:0]       edge_pulse;
  logic [NCH-1:0]       edge_flag;
  logic [NCH*CNT_W-1:0] edge_cnt;

  multi_edge_detect #(
    .NCH(NCH), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN),
    .CNT_W(CNT_W), .IDLE_VAL(IDLE_VAL)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr),
    .level(level), .edge_pulse(edge_pulse), .edge_flag(edge_flag),
    .edge_cnt(edge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                   edge_no;
    logic [NCH-1:0]       lvl;
    logic [NCH-1:0]       pls;
    logic [NCH-1:0]       flg;
    logic [NCH*CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: a level change is accepted once the synchronised input has
  // differed from the accepted level for FILT_LEN consecutive edges, counted
  // from the last reset or acceptance on that channel.
  logic [NCH-1:0] samp_hist[$];
  int             edge_no = 0;
  int             last_reset = 0;
  int             last_event[NCH];
  logic [NCH-1:0] lvl_m;
  logic [NCH-1:0] pls_m;
  logic [NCH-1:0] flg_m;
  int             cnt_m[NCH];

  function automatic logic [NCH-1:0] syncAt(int m);
    int src;
    src = m - SYNC_STAGES;
    if (src < 0 || src < last_reset) return {NCH{IDLE_VAL}};
    return samp_hist[src];
  endfunction

  task automatic modelStep();
    bit ok;
    bit qual;
    logic nl;
    samp_hist.push_back(rst ? {NCH{IDLE_VAL}} : din);
    if (rst) begin
      last_reset = edge_no;
      lvl_m = {NCH{IDLE_VAL}};
      pls_m = '0;
      flg_m = '0;
      for (int c = 0; c < NCH; c++) begin
        cnt_m[c] = 0;
        last_event[c] = edge_no;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        ok = (edge_no - FILT_LEN + 1) > last_event[c];
        for (int j = 0; j < FILT_LEN && ok; j++) begin
          if (syncAt(edge_no - j)[c] == lvl_m[c]) ok = 0;
        end
        qual = 0;
        if (ok) begin
          nl = syncAt(edge_no)[c];
          lvl_m[c] = nl;
          last_event[c] = edge_no;
          qual = (mode == 2'b11) || (mode == 2'b01 && nl) || (mode == 2'b10 && !nl);
        end
        pls_m[c] = qual;
        if (qual) flg_m[c] = 1'b1;
        else if (clr[c]) flg_m[c] = 1'b0;
        if (clr[c]) cnt_m[c] = qual ? 1 : 0;
        else if (qual && cnt_m[c] < CNT_SAT) cnt_m[c] = cnt_m[c] + 1;
      end
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] d, input logic [1:0] m,
                               input logic [NCH-1:0] c, input logic r);
    exp_t e;
    din  = d;
    mode = m;
    clr  = c;
    rst  = r;
    modelStep();
    e.edge_no = edge_no;
    e.lvl = lvl_m;
    e.pls = pls_m;
    e.flg = flg_m;
    for (int k = 0; k < NCH; k++) e.cnt[k*CNT_W +: CNT_W] = cnt_m[k][CNT_W-1:0];
    @(posedge clk);
    exp_q.push_back(e);
    edge_no++;
    #2;
  endtask

  task automatic checkOutput(input string name, input int en,
                             input logic [NCH*CNT_W-1:0] act,
                             input logic [NCH*CNT_W-1:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("[TB] FAIL %s edge %0d: got %h, expected %h", name, en, act, want);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is retired per edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("level", e.edge_no, (NCH*CNT_W)'(level), (NCH*CNT_W)'(e.lvl));
        checkOutput("edge_pulse", e.edge_no, (NCH*CNT_W)'(edge_pulse), (NCH*CNT_W)'(e.pls));
        checkOutput("edge_flag", e.edge_no, (NCH*CNT_W)'(edge_flag), (NCH*CNT_W)'(e.flg));
        checkOutput("edge_cnt", e.edge_no, edge_cnt, e.cnt);
      end
    end
  end

  initial begin
    logic [NCH-1:0] d;
    logic [NCH-1:0] c;
    logic [1:0]     m;
    d = '1;
    m = 2'b11;

    // Reset and idle hold with all lines high.
    for (int k = 0; k < 3; k++) applyStimulus(d, m, '0, 1'b1);
    for (int k = 0; k < 20; k++) applyStimulus(d, m, '0, 1'b0);

    // Falling edge on channel 0 in both-edge mode.
    d[0] = 1'b0;
    for (int k = 0; k < 10; k++) applyStimulus(d, m, '0, 1'b0);

    // Rising-only mode: short glitch, long low, then release high on channel 1.
    m = 2'b01;
    d[1] = 1'b0; for (int k = 0; k < 3; k++)  applyStimulus(d, m, '0, 1'b0);
    d[1] = 1'b1; for (int k = 0; k < 6; k++)  applyStimulus(d, m, '0, 1'b0);
    d[1] = 1'b0; for (int k = 0; k < 10; k++) applyStimulus(d, m, '0, 1'b0);
    d[1] = 1'b1; for (int k = 0; k < 10; k++) applyStimulus(d, m, '0, 1'b0);

    // Saturate channel 2, then clear exactly on an acceptance edge.
    m = 2'b11;
    for (int t = 0; t < 300; t++) begin
      d[2] = ~d[2];
      for (int k = 0; k < 8; k++) applyStimulus(d, m, '0, 1'b0);
    end
    d[2] = ~d[2];
    for (int k = 0; k < 8; k++) applyStimulus(d, m, (k == 5) ? 4'b0100 : 4'b0000, 1'b0);

    // Mode off tracks level silently; falling-only then counts the next fall.
    m = 2'b00;
    for (int t = 0; t < 4; t++) begin
      d[3] = ~d[3];
      for (int k = 0; k < 8; k++) applyStimulus(d, m, '0, 1'b0);
    end
    m = 2'b10;
    for (int t = 0; t < 2; t++) begin
      d[3] = ~d[3];
      for (int k = 0; k < 8; k++) applyStimulus(d, m, '0, 1'b0);
    end

    // Reset in the middle of filtering discards the pending change.
    m = 2'b11;
    d = '1;
    for (int k = 0; k < 10; k++) applyStimulus(d, m, '0, 1'b0);
    d[0] = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(d, m, '0, 1'b0);
    applyStimulus(d, m, '0, 1'b1);
    d[0] = 1'b1;
    applyStimulus(d, m, '0, 1'b1);
    for (int k = 0; k < 12; k++) applyStimulus(d, m, '0, 1'b0);

    // Random traffic: sparse bit flips, occasional mode changes, clears and resets.
    for (int k = 0; k < 2500; k++) begin
      for (int b = 0; b < NCH; b++) begin
        if ($urandom_range(0, 5) == 0) d[b] = ~d[b];
      end
      if ($urandom_range(0, 49) == 0) m = 2'($urandom_range(0, 3));
      c = '0;
      for (int b = 0; b < NCH; b++) begin
        if ($urandom_range(0, 19) == 0) c[b] = 1'b1;
      end
      applyStimulus(d, m, c, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 12; k++) applyStimulus(d, m, '0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", edge_no, (NCH*CNT_W)'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_edge_detect.md
MULTI_EDGE_DETECT -- requirements
Module: multi_edge_detect

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  NCH, 4, number of independent input channels (1..32)
  SYNC_STAGES, 2, synchroniser flops per channel (>=2)
  FILT_LEN, 4, consecutive stable cycles required to accept a level change (1..255)
  CNT_W, 8, width of each per-channel edge counter (>=2)
  IDLE_VAL, 1'b1, reset level of synchroniser and filtered level (bus idle)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  sole clock, all state on rising edge
  rst  input  1  reset, synchronous, active-high
  din  input  NCH  asynchronous raw line inputs
  mode  input  2  edge select: 00 off, 01 rising, 10 falling, 11 both
  clr  input  NCH  per-channel clear of flag and count
  level  output  NCH  filtered line level
  edge_pulse  output  NCH  one-cycle pulse per accepted edge
  edge_flag  output  NCH  sticky edge-seen flag
  edge_cnt  output  NCH*CNT_W  per-channel counts, channel i at [i*CNT_W +: CNT_W]
REQ-003 Reset SHALL be synchronous and active-high, sampled only on rising clk; one clock, no other clock or async reset.

Function
REQ-004 Each channel SHALL pass din[i] through SYNC_STAGES flops; only the last stage output (sync[i]) feeds downstream logic.
REQ-005 Per channel, a filter counter (width ceil(log2(FILT_LEN+1))) SHALL increment each cycle sync[i] != level[i], and reset to 0 in any cycle sync[i] == level[i].
REQ-006 When the counter would reach FILT_LEN, level[i] SHALL take sync[i] on that edge and the counter SHALL return to 0; glitches shorter than FILT_LEN cycles SHALL never change level[i].
REQ-007 An accepted transition SHALL be rising if level goes 0->1, falling if 1->0; it is qualifying if mode is 11, or 01 and rising, or 10 and falling.
REQ-008 edge_pulse[i] SHALL be high for exactly the one cycle after the edge on which a qualifying transition is accepted, low otherwise.
REQ-009 Latency: a din level change first sampled at edge E0 and held stable SHALL produce level change and edge_pulse registered at edge E0+SYNC_STAGES+FILT_LEN-1 (defaults: 5 edges after E0).
REQ-010 edge_flag[i] SHALL set on a qualifying transition and hold until clr[i]; if clr[i] and a qualifying transition coincide, flag SHALL be 1 (set wins).
REQ-011 edge_cnt channel i SHALL increment by 1 per qualifying transition and saturate at 2^CNT_W-1 (no wrap).
REQ-012 clr[i] SHALL zero count i on the next edge; coincident with a qualifying transition, count SHALL become 1.
REQ-013 mode SHALL be sampled on the acceptance edge; mode 00 suppresses pulse, flag and count updates, but level and filter SHALL keep tracking.
REQ-014 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be reported in the same cycle.
REQ-015 clr bits on channels without events SHALL affect only that channel.

Reset
REQ-016 While rst is high at a rising edge: all sync flops and level = IDLE_VAL, filter counters = 0, edge_pulse = 0, edge_flag = 0, edge_cnt = 0.
REQ-017 rst asserted mid-filtering SHALL discard the pending transition; no pulse SHALL follow from pre-reset input activity unless din differs from IDLE_VAL after reset (then treated as a fresh change).
REQ-018 All outputs SHALL be registered; no combinational path from din, mode or clr to any output.

Verification (defaults NCH=4, SYNC_STAGES=2, FILT_LEN=4, CNT_W=8, IDLE_VAL=1)
REQ-019 Reset, din=4'hF held -> level=4'hF, pulse/flag/cnt all 0 for 20 cycles.
REQ-020 mode=11, din[0] 1->0 held -> edge_pulse[0] high exactly one cycle, 5 edges after sampling edge; level[0]=0; flag[0]=1; cnt0=1.
REQ-021 mode=01, din[1] glitches low 3 cycles then low 10 cycles then high -> one rising pulse only, no pulse for glitch or fall; cnt1=1.
REQ-022 mode=11, 300 toggles on din[2] (each held 8 cycles) -> cnt2 saturates at 255; clr[2] coinciding with a pulse -> flag[2]=1, cnt2=1.
REQ-023 mode=00, toggle din[3] -> level[3] follows, no pulse/flag/count change; switch mode=10 -> next falling edge counted.
REQ-024 din[0] driven low, rst asserted 2 cycles after filter starts counting, din returned high before release -> no pulse, all outputs at reset values.
